// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative HI/LO multiply/divide controller.
// One bit per cycle: shift-add multiplier or restoring divider over WIDTH
// iterations, followed by a sign-correction/write-back step.
// Optional build macro MULDIV_ZERO_DETECT_EN: a divide with a zero divisor
// skips the iterations, finishes one edge after start and pulses div_zero.
//
// Handshake: start is a single-cycle request sampled only while busy=0
// (state IDLE); it is ignored otherwise. done pulses for one cycle when HI/LO
// hold the new result, and busy is already low in that cycle, so a new start
// may be presented in the done cycle. stall = busy & hilo_rd (combinational).
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  input  logic             hilo_rd,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall
`ifdef MULDIV_ZERO_DETECT_EN
  ,
  output logic             div_zero
`endif
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CALC   = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  // Multiply: {upper partial product, multiplier being shifted out}.
  // Divide:   {remainder, dividend shifting out / quotient shifting in}.
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     b_q, b_d;          // multiplicand or divisor magnitude
  logic                 is_div_q, is_div_d;
  logic                 neg_q, neg_d;      // negate product / quotient
  logic                 rem_neg_q, rem_neg_d;
  logic                 zero_q, zero_d;    // zero-divisor shortcut taken
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;

  logic [WIDTH-1:0]     rs_abs, rt_abs;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_shift;
  logic                 div_ge;
  logic [WIDTH-1:0]     div_rem;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      b_q       <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      zero_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      b_q       <= b_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      zero_q    <= zero_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  // Next-state, iteration datapath and HI/LO write-back.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    b_d       = b_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    zero_d    = zero_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    // Operand magnitudes; only the signed ops (op[0]=1) take absolute values.
    rs_abs = (op[0] && rs_data[WIDTH-1]) ? -rs_data : rs_data;
    rt_abs = (op[0] && rt_data[WIDTH-1]) ? -rt_data : rt_data;

    // One multiply step: add multiplicand when the current multiplier bit is set.
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);

    // One restoring divide step; a fitted subtract always yields < divisor.
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, b_q});
    div_rem   = div_ge ? (div_shift[WIDTH-1:0] - b_q) : div_shift[WIDTH-1:0];

    // Sign correction applied on write-back.
    prod_fix = neg_q ? -acc_q : acc_q;
    quo_fix  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    case (state_q)
      S_IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start) begin
          is_div_d  = op[1];
          neg_d     = op[0] & (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
          rem_neg_d = op[0] & rs_data[WIDTH-1];
          zero_d    = 1'b0;
          cnt_d     = CNT_W'(WIDTH);
          state_d   = S_CALC;
          if (op[1]) begin
            acc_d = {{WIDTH{1'b0}}, rs_abs};
            b_d   = rt_abs;
          end else begin
            acc_d = {{WIDTH{1'b0}}, rt_abs};
            b_d   = rs_abs;
          end
`ifdef MULDIV_ZERO_DETECT_EN
          if (op[1] && (rt_data == '0)) begin
            // Result is known up front: HI = raw dividend, LO = all ones.
            zero_d  = 1'b1;
            acc_d   = {rs_data, {WIDTH{1'b1}}};
            cnt_d   = '0;
            state_d = S_FINISH;
          end
`endif
        end
      end
      S_CALC: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (is_div_q) acc_d = {div_rem, acc_q[WIDTH-2:0], div_ge};
        else          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        if (cnt_q == CNT_W'(1)) state_d = S_FINISH;
      end
      S_FINISH: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
        if (zero_q) begin
          hi_d = acc_q[2*WIDTH-1:WIDTH];
          lo_d = acc_q[WIDTH-1:0];
        end else if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign hi    = hi_q;
  assign lo    = lo_q;
  assign busy  = (state_q != S_IDLE);
  assign done  = done_q;
  assign stall = busy & hilo_rd;
`ifdef MULDIV_ZERO_DETECT_EN
  assign div_zero = done_q & zero_q;
`endif

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Testbench for muldiv_sequencer: directed vector table, hand-written
// multi-cycle sequences and randomized back-to-back operations checked
// against an arithmetic reference model.
module tb_muldiv_sequencer;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] rs_data, rt_data, wdata;
  logic         hi_we, lo_we, hilo_rd;
  logic [W-1:0] hi, lo;
  logic         busy, done, stall;
`ifdef MULDIV_ZERO_DETECT_EN
  logic         div_zero;
`endif

  int checks = 0;
  int failures = 0;

  muldiv_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .hilo_rd(hilo_rd),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .stall(stall)
`ifdef MULDIV_ZERO_DETECT_EN
    , .div_zero(div_zero)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Reference model straight from the arithmetic rules; returns {hi, lo}.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [63:0] p;
    logic [W-1:0] ua, ub, q, r;
    longint sa, sb;
    if (o == 2'b00) begin
      p = {32'h0, a} * {32'h0, b};
    end else if (o == 2'b01) begin
      sa = $signed(a);
      sb = $signed(b);
      p = sa * sb;
    end else begin
      ua = (o[0] && a[W-1]) ? -a : a;
      ub = (o[0] && b[W-1]) ? -b : b;
      if (ub == 0) begin
        q = '1;
        r = ua;
      end else begin
        q = ua / ub;
        r = ua % ub;
      end
      if (o[0] && (a[W-1] ^ b[W-1])) q = -q;
      if (o[0] && a[W-1]) r = -r;
      p = {r, q};
`ifdef MULDIV_ZERO_DETECT_EN
      if (b == 0) p = {a, 32'hFFFFFFFF};
`endif
    end
    return p;
  endfunction

  function automatic int exp_lat(input logic [1:0] o, input logic [W-1:0] b);
`ifdef MULDIV_ZERO_DETECT_EN
    if (o[1] && b == 0) return 2;
`endif
    return 34;
  endfunction

  // ---------------- driver tasks ----------------
  // Present a request at the current point (after a negedge); it is taken
  // at the following posedge (E0).
  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Count negedges after E0 until done is seen; lat = -1 on timeout.
  task automatic wait_done(output int lat, output int busy_n, output logic dz);
    lat = -1; busy_n = 0; dz = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (done) begin
        lat = k;
`ifdef MULDIV_ZERO_DETECT_EN
        dz = div_zero;
`endif
        break;
      end
    end
    if (lat < 0) begin
      failures++;
      $display("FAIL done_timeout no done within 100 cycles");
    end
  endtask

  // Full single-operation check including latency, busy span and pulse width.
  task automatic run_vec(input string name, input logic [1:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el);
    int lat, bn;
    logic dz;
    @(negedge clk);
    issue(o, a, b);
    wait_done(lat, bn, dz);
    check({name, ".lat"}, 64'(lat), 64'(exp_lat(o, b)));
    check({name, ".busy_cycles"}, 64'(bn), 64'(exp_lat(o, b) - 1));
    check({name, ".busy_at_done"}, {63'b0, busy}, 64'd0);
    check({name, ".hi"}, {32'b0, hi}, {32'b0, eh});
    check({name, ".lo"}, {32'b0, lo}, {32'b0, el});
`ifdef MULDIV_ZERO_DETECT_EN
    check({name, ".div_zero"}, {63'b0, dz}, {63'b0, (o[1] && b == 0)});
`endif
    @(negedge clk);
    check({name, ".done_one_cycle"}, {63'b0, done}, 64'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string        name;
    logic [1:0]   o;
    logic [W-1:0] a, b, eh, el;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int lat, bn, dn, stall_at_done;
    logic dz;
    logic [63:0] exp_hl;
    logic [W-1:0] ra, rb;
    logic [1:0] ro;

    start = 0; op = 0; rs_data = 0; rt_data = 0;
    hi_we = 0; lo_we = 0; wdata = 0; hilo_rd = 0;

    vecs[0] = '{"divu_100_7",      2'b10, 32'd100,      32'd7,        32'h00000002, 32'h0000000E};
    vecs[1] = '{"div_m7_2",        2'b11, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[2] = '{"mult_m3_5",       2'b01, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[3] = '{"multu_max",       2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[4] = '{"div_min_m1",      2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5] = '{"divu_by_zero",    2'b10, 32'hABCD0000, 32'd0,        32'hABCD0000, 32'hFFFFFFFF};
    vecs[6] = '{"divu_9_3",        2'b10, 32'd9,        32'd3,        32'h00000000, 32'h00000003};
    vecs[7] = '{"div_7_m2",        2'b11, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[8] = '{"mult_min_min",    2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[9] = '{"multu_x_0",       2'b00, 32'h12345678, 32'd0,        32'h00000000, 32'h00000000};

    do_reset();

    // Reset state
    @(negedge clk);
    check("reset.hi",    {32'b0, hi}, 64'd0);
    check("reset.lo",    {32'b0, lo}, 64'd0);
    check("reset.busy",  {63'b0, busy}, 64'd0);
    check("reset.done",  {63'b0, done}, 64'd0);
    check("reset.stall", {63'b0, stall}, 64'd0);

    for (int i = 0; i < 10; i++)
      run_vec(vecs[i].name, vecs[i].o, vecs[i].a, vecs[i].b, vecs[i].eh, vecs[i].el);

    // MTHI / MTLO while idle
    @(negedge clk);
    hi_we = 1; wdata = 32'h12345678;
    @(negedge clk);
    hi_we = 0; lo_we = 1; wdata = 32'h0BADF00D;
    @(negedge clk);
    lo_we = 0;
    check("mthi.hi", {32'b0, hi}, 64'h12345678);
    check("mtlo.lo", {32'b0, lo}, 64'h0BADF00D);

    // MULTU with stray start, hi_we during busy and hilo_rd stall
    hilo_rd = 1;
    issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
    @(negedge clk);
    check("stall.busy", {63'b0, stall}, 64'd1);
    repeat (5) @(negedge clk);
    start = 1; op = 2'b10; rs_data = 32'd1; rt_data = 32'd1;
    hi_we = 1; wdata = 32'hDEADBEEF;
    @(posedge clk);
    #1 start = 0; hi_we = 0;
    dn = 0; stall_at_done = -1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done) begin
        dn++;
        stall_at_done = int'(stall);
      end
    end
    hilo_rd = 0;
    check("busy_start.done_count", 64'(dn), 64'd1);
    check("busy_start.stall_at_done", 64'(stall_at_done), 64'd0);
    check("busy_we.hi", {32'b0, hi}, 64'hFFFFFFFE);
    check("busy_we.lo", {32'b0, lo}, 64'h00000001);

    // start and hi_we together in IDLE: write lands, result overwrites
    hi_we = 1; wdata = 32'hCAFEF00D;
    issue(2'b00, 32'd3, 32'd4);
    hi_we = 0;
    @(negedge clk);
    check("start_we.hi_early", {32'b0, hi}, 64'hCAFEF00D);
    wait_done(lat, bn, dz);
    check("start_we.lat", 64'(lat), 64'd33);
    check("start_we.hi", {32'b0, hi}, 64'd0);
    check("start_we.lo", {32'b0, lo}, 64'd12);

    // Reset mid-operation
    @(negedge clk);
    issue(2'b10, 32'd100, 32'd7);
    repeat (10) @(negedge clk);
    reset = 1;
    @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    check("midreset.busy", {63'b0, busy}, 64'd0);
    check("midreset.done", {63'b0, done}, 64'd0);
    check("midreset.hi", {32'b0, hi}, 64'd0);
    check("midreset.lo", {32'b0, lo}, 64'd0);
    repeat (40) @(negedge clk);
    check("midreset.no_done", {63'b0, done}, 64'd0);
    run_vec("after_reset_divu_9_3", 2'b10, 32'd9, 32'd3, 32'd0, 32'd3);

    // Randomized back-to-back operations: each start is issued in the done cycle
    @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       ra = 32'($urandom_range(0, 255));
        1:       ra = 32'h80000000 | $urandom;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFFFFFF - 32'($urandom_range(0, 3));
        default: rb = $urandom;
      endcase
      exp_hl = model(ro, ra, rb);
      issue(ro, ra, rb);
      wait_done(lat, bn, dz);
      check($sformatf("rand%0d.lat", i), 64'(lat), 64'(exp_lat(ro, rb)));
      check($sformatf("rand%0d.hilo op=%0d a=%h b=%h", i, ro, ra, rb), {hi, lo}, exp_hl);
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Multi-cycle controller for the CPU's HI/LO multiply/divide unit. It accepts MULT/MULTU/DIV/DIVU requests from the execute stage and runs an iterative shift-add multiplier or restoring divider, one bit per cycle. It owns the HI/LO registers, services MTHI/MTLO writes, and tells the pipeline to stall when MFHI/MFLO is issued while a result is still pending.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits
CNT_W, 6, iteration counter width; must hold the value WIDTH

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
start  in  1  request pulse; sampled only in IDLE
op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
rs_data  in  WIDTH  multiplicand or dividend
rt_data  in  WIDTH  multiplier or divisor
hi_we  in  1  MTHI write strobe
lo_we  in  1  MTLO write strobe
wdata  in  WIDTH  MTHI/MTLO data
hilo_rd  in  1  MFHI/MFLO is in the execute stage
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register
busy  out  1  operation in progress
done  out  1  one-cycle completion pulse
stall  out  1  combinational: busy & hilo_rd

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE.
  - hi=0, lo=0, busy=0, done=0, counter=0.
  - Reset mid-operation abandons the operation with no HI/LO update.
- State IDLE:
  - On start=1 at edge E0: latch op, latch |rs|,|rt| (signed ops) or raw values (unsigned ops), record the result signs, load counter=WIDTH, go to CALC.
- State CALC, one iteration per edge (E1..E32):
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring step; remainder<<1 | next dividend bit; if remainder>=divisor, subtract and set quotient bit=1.
  - Counter decrements by 1 each edge; when counter reaches 1, go to FINISH.
- State FINISH (edge E33):
  - Apply sign correction.
    - MULT: negate the 64-bit product if the operand signs differ.
    - DIV: quotient negated if signs differ; remainder takes the dividend's sign.
  - Write hi/lo: product[63:32]/[31:0], or remainder/quotient.
  - done=1 for exactly the cycle after E33; go to IDLE.
- busy:
  - Asserted from the cycle after E0 through the cycle after E32 (33 cycles).
  - Deasserted in the same cycle done is asserted.
- Latency: start edge to hi/lo valid is 33 edges. A new start is accepted in the cycle where done=1, so back-to-back operations are possible.
- start while busy: ignored; no queueing.
- hi_we/lo_we:
  - Applied at the edge only when busy=0.
  - Ignored while busy, because the pipeline is stalled.
  - If start and hi_we/lo_we are asserted together in IDLE, the write applies; the later FINISH result overwrites it.
- Signed corner case: DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (wraps, no trap).
- Divide by zero (without the feature below) runs the full algorithm:
  - DIVU gives lo=0xFFFFFFFF, hi=dividend.
  - DIV follows the same datapath plus the sign fix.
- hi/lo hold their values at all other times.

Optional Feature:
Macro: MULDIV_ZERO_DETECT_EN.
- Defined:
  - A divide with rt_data==0 skips CALC; FINISH is reached at E1.
  - hi=rs_data, lo=0xFFFFFFFF; done pulses in the cycle after E1.
  - Adds an output div_zero (1 bit), which pulses with done.
- Not defined:
  - No div_zero port.
  - A zero divisor takes the full 33-edge path with the results above.

Test Plan:
- Reset, then DIVU rs=100, rt=7 -> busy for 33 cycles; done pulse; lo=0x0000000E, hi=0x00000002.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then MULT rs=0xFFFFFFFD, rt=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULTU rs=rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. start pulsed again mid-CALC is ignored; exactly one done pulse.
- MTHI wdata=0x12345678 while idle -> hi=0x12345678. hi_we during busy leaves the final hi equal to the computed result. hilo_rd=1 during busy -> stall=1; stall=0 once done.
- DIVU rs=0xABCD0000, rt=0:
  - Macro off: 33-cycle latency, lo=0xFFFFFFFF, hi=0xABCD0000.
  - Macro on: done in the cycle after E1, div_zero=1, same hi/lo.
- DIVU started, reset asserted at iteration 10 -> next cycle busy=0, done=0, hi=lo=0. A subsequent DIVU 9/3 gives lo=3, hi=0.
